// File: rtl/control_types.sv
`default_nettype none
// ============================================================================
// control_types : memory-op encoding shared with the control decoder, plus
//                 the LSU state encoding. Rev 1.0
// ============================================================================
package control_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// lsu_load_align : selects the addressed lane of a read word and sign/zero
//                  extends it to 32 bits. Rev 1.0
// ============================================================================
module lsu_load_align
  import control_types::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (byte_sel)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    half_val = byte_sel[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (op)
      MEM_LB:  data = {{24{byte_val[7]}}, byte_val};
      MEM_LBU: data = {24'd0, byte_val};
      MEM_LH:  data = {{16{half_val[15]}}, half_val};
      MEM_LHU: data = {16'd0, half_val};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : MEM-stage byte/half/word load-store engine on a
//                   word-addressed req/gnt/rvalid bus, stalling until done. Rev 1.0
// ============================================================================
module load_store_unit
  import control_types::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  mem_op_t           mem_ctrl_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic              stall_out,
  output logic [31:0]       rdata_out,
  output logic              done_out,
  output logic              misalign_out,
  output logic              bus_err_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  lsu_state_t        state, next_state;
  mem_op_t           op_reg;
  logic [1:0]        lane_reg;
  logic              we_reg;
  logic [TW-1:0]     timer;
  logic              accept, misal, start, capture, timeout_hit, abort;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       load_data;

  assign accept  = (state == IDLE) && valid_in && (mem_rd_in || mem_wr_in) &&
                   (mem_ctrl_in != MEM_NOP);
  assign misal   = is_misaligned(mem_ctrl_in, addr_in[1:0]);
  assign start   = accept && !misal;
  assign capture = ((state == REQ) && bus_gnt && !we_reg && bus_rvalid) ||
                   ((state == WAIT_R) && bus_rvalid);
  assign timeout_hit = (TIMEOUT != 0) && ((state == REQ) || (state == WAIT_R)) &&
                       (timer == T_LAST);

  // Lane placement is resolved at accept time so the bus fields are registers.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = 32'd0;
    case (mem_ctrl_in)
      MEM_SB: begin
        st_be    = 4'b0001 << addr_in[1:0];
        st_wdata = {4{wdata_in[7:0]}};
      end
      MEM_SH: begin
        st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_in[15:0]}};
      end
      MEM_SW: st_wdata = wdata_in;
      default: begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      IDLE: if (start) next_state = REQ;
      REQ: begin
        if (bus_gnt) begin
          if (we_reg || bus_rvalid) next_state = DONE;
          else                      next_state = WAIT_R;
        end else if (timeout_hit) begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      WAIT_R: begin
        if (bus_rvalid) begin
          next_state = DONE;
        end else if (timeout_hit) begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_reg       <= MEM_NOP;
      lane_reg     <= 2'd0;
      we_reg       <= 1'b0;
      timer        <= '0;
      rdata_out    <= 32'd0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
    end else begin
      state        <= next_state;
      misalign_out <= accept && misal;
      bus_err_out  <= abort;
      if (start) begin
        op_reg    <= mem_ctrl_in;
        lane_reg  <= addr_in[1:0];
        we_reg    <= is_store(mem_ctrl_in);
        bus_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
        bus_be    <= st_be;
        bus_wdata <= st_wdata;
        timer     <= '0;
      end else if ((state == REQ) || (state == WAIT_R)) begin
        timer <= timer + 1'b1;
      end
      if (capture) rdata_out <= load_data;
    end
  end

  assign stall_out = start || (state == REQ) || (state == WAIT_R);
  assign bus_req   = (state == REQ);
  assign bus_we    = (state == REQ) && we_reg;
  assign done_out  = (state == DONE);

  lsu_load_align u_align (
    .op       (op_reg),
    .byte_sel (lane_reg),
    .rdata    (bus_rdata),
    .data     (load_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
  import control_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  mem_op_t     mem_ctrl_in;
  logic        mem_rd_in, mem_wr_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, done_out, misalign_out, bus_err_out;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_ctrl_in(mem_ctrl_in),
    .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .rdata_out(rdata_out), .done_out(done_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in    = 1'b0;
    mem_ctrl_in = MEM_NOP;
    mem_rd_in   = 1'b0;
    mem_wr_in   = 1'b0;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
  endtask

  task automatic present(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd);
    valid_in    = 1'b1;
    mem_ctrl_in = op;
    mem_rd_in   = !is_store(op);
    mem_wr_in   = is_store(op);
    addr_in     = a;
    wdata_in    = wd;
  endtask

  // Runs one aligned access; gnt comes gnt_dly cycles into REQ, rvalid rv_dly cycles after gnt.
  task automatic run_access(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                            output int stalls, output int dones, output logic o_req,
                            output logic [31:0] o_addr, output logic [3:0] o_be,
                            output logic o_we, output logic [31:0] o_wdata);
    logic fin;
    present(op, a, wd);
    #1;
    stalls = stall_out ? 1 : 0;
    dones  = 0;
    cyc();
    valid_in = 1'b0; mem_ctrl_in = MEM_NOP; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
    #1;
    o_req = bus_req; o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
    fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      bus_gnt    = (c == gnt_dly);
      bus_rvalid = !is_store(op) && (c == gnt_dly + rv_dly);
      bus_rdata  = bus_rvalid ? rd : 32'hCAFE_F00D;
      #1;
      if (stall_out) stalls++;
      if (done_out) dones++;
      if (dones > 0 && !done_out) fin = 1'b1;
      else cyc();
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    addr_in = 32'h0; wdata_in = 32'h0; bus_rdata = 32'h0;
    repeat (3) cyc();
    checks++;
    if ({stall_out, done_out, misalign_out, bus_err_out, bus_req, bus_we} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000",
               {stall_out, done_out, misalign_out, bus_err_out, bus_req, bus_we});
    end
    checks++;
    if (rdata_out !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got rdata=%h addr=%h be=%h wdata=%h expected all zero",
               rdata_out, bus_addr, bus_be, bus_wdata);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_store();
    int st, dn; logic rq, we; logic [31:0] ad, wd; logic [3:0] be;
    run_access(MEM_SW, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rq !== 1'b1 || ad !== 32'h100 || be !== 4'b1111 || we !== 1'b1 || wd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_bus: got req=%b addr=%h be=%b we=%b wdata=%h expected 1 100 1111 1 deadbeef",
               rq, ad, be, we, wd);
    end
    checks++;
    if (st !== 3 || dn !== 1) begin
      fails++;
      $display("FAIL sw_timing: got stall=%0d done=%0d expected 3 1", st, dn);
    end
    run_access(MEM_SB, 32'h103, 32'h000000A5, 0, 0, 32'h0, st, dn, rq, ad, be, we, wd);
    checks++;
    if (ad !== 32'h100 || be !== 4'b1000 || wd !== 32'hA5A5A5A5 || we !== 1'b1) begin
      fails++;
      $display("FAIL sb_lanes: got addr=%h be=%b wdata=%h we=%b expected 100 1000 a5a5a5a5 1",
               ad, be, wd, we);
    end
    run_access(MEM_SH, 32'h206, 32'h1234BEEF, 0, 0, 32'h0, st, dn, rq, ad, be, we, wd);
    checks++;
    if (ad !== 32'h204 || be !== 4'b1100 || wd !== 32'hBEEFBEEF || dn !== 1) begin
      fails++;
      $display("FAIL sh_lanes: got addr=%h be=%b wdata=%h done=%0d expected 204 1100 beefbeef 1",
               ad, be, wd, dn);
    end
  endtask

  task automatic test_loads();
    int st, dn; logic rq, we; logic [31:0] ad, wd; logic [3:0] be;
    run_access(MEM_LB, 32'h101, 32'h0, 0, 2, 32'h123480FF, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'hFFFFFF80 || be !== 4'b1111 || we !== 1'b0 || ad !== 32'h100) begin
      fails++;
      $display("FAIL lb: got rdata=%h be=%b we=%b addr=%h expected ffffff80 1111 0 100",
               rdata_out, be, we, ad);
    end
    checks++;
    if (st !== 4 || dn !== 1) begin
      fails++;
      $display("FAIL lb_wait_timing: got stall=%0d done=%0d expected 4 1", st, dn);
    end
    run_access(MEM_LBU, 32'h101, 32'h0, 1, 0, 32'h123480FF, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'h00000080) begin
      fails++;
      $display("FAIL lbu: got %h expected 00000080", rdata_out);
    end
    run_access(MEM_LHU, 32'h102, 32'h0, 0, 1, 32'h123480FF, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'h00001234) begin
      fails++;
      $display("FAIL lhu: got %h expected 00001234", rdata_out);
    end
    run_access(MEM_LH, 32'h100, 32'h0, 0, 0, 32'h00008001, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh: got %h expected ffff8001", rdata_out);
    end
    run_access(MEM_LW, 32'h104, 32'h0, 0, 0, 32'h89ABCDEF, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'h89ABCDEF || st !== 2 || dn !== 1) begin
      fails++;
      $display("FAIL lw_same_cycle: got rdata=%h stall=%0d done=%0d expected 89abcdef 2 1",
               rdata_out, st, dn);
    end
    run_access(MEM_SW, 32'h108, 32'h55555555, 0, 0, 32'h0, st, dn, rq, ad, be, we, wd);
    checks++;
    if (rdata_out !== 32'h89ABCDEF) begin
      fails++;
      $display("FAIL store_keeps_rdata: got %h expected 89abcdef", rdata_out);
    end
  endtask

  task automatic test_misalign();
    present(MEM_LW, 32'h202, 32'h0);
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      fails++;
      $display("FAIL misalign_stall: got %b expected 0", stall_out);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (misalign_out !== 1'b1 || bus_req !== 1'b0 || stall_out !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pulse: got mis=%b req=%b stall=%b expected 1 0 0",
               misalign_out, bus_req, stall_out);
    end
    present(MEM_SH, 32'h301, 32'h0);
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (misalign_out !== 1'b1 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL misalign_sh: got mis=%b req=%b expected 1 0", misalign_out, bus_req);
    end
    cyc();
    checks++;
    if (misalign_out !== 1'b0 || bus_req !== 1'b0 || done_out !== 1'b0) begin
      fails++;
      $display("FAIL misalign_after: got mis=%b req=%b done=%b expected 0 0 0",
               misalign_out, bus_req, done_out);
    end
  endtask

  task automatic test_back_to_back();
    present(MEM_LW, 32'h300, 32'h0);
    cyc();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b1 || stall_out !== 1'b0 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: got done=%b stall=%b req=%b expected 1 0 0",
               done_out, stall_out, bus_req);
    end
    cyc();
    checks++;
    if (stall_out !== 1'b1 || bus_req !== 1'b0 || done_out !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: got stall=%b req=%b done=%b expected 1 0 0",
               stall_out, bus_req, done_out);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      fails++;
      $display("FAIL b2b_req: got %b expected 1", bus_req);
    end
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h22222222;
    cyc();
    idle_inputs();
    cyc();
    checks++;
    if (rdata_out !== 32'h22222222) begin
      fails++;
      $display("FAIL b2b_rdata: got %h expected 22222222", rdata_out);
    end
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int err_at = -1;
    present(MEM_LW, 32'h400, 32'h0);
    cyc();
    idle_inputs();
    for (int c = 0; c < 10 && err_at < 0; c++) begin
      #1;
      if (bus_req) reqs++;
      if (bus_err_out) err_at = c;
      else cyc();
    end
    checks++;
    if (reqs !== 4 || err_at !== 4) begin
      fails++;
      $display("FAIL timeout_len: got req_cycles=%0d err_at=%0d expected 4 4", reqs, err_at);
    end
    checks++;
    if (stall_out !== 1'b0 || bus_req !== 1'b0 || rdata_out !== 32'h22222222) begin
      fails++;
      $display("FAIL timeout_state: got stall=%b req=%b rdata=%h expected 0 0 22222222",
               stall_out, bus_req, rdata_out);
    end
    cyc();
    checks++;
    if (bus_err_out !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: got %b expected 0", bus_err_out);
    end
  endtask

  task automatic test_reset_mid_access();
    present(MEM_LW, 32'h500, 32'h0);
    cyc();
    idle_inputs();
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b1 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL wait_r_state: got stall=%b req=%b expected 1 0", stall_out, bus_req);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0 || bus_req !== 1'b0 || rdata_out !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: got stall=%b req=%b rdata=%h expected 0 0 0",
               stall_out, bus_req, rdata_out);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
    cyc();
    bus_rvalid = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b0 || rdata_out !== 32'h0) begin
      fails++;
      $display("FAIL stray_rvalid: got done=%b rdata=%h expected 0 0", done_out, rdata_out);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
